mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one unified, fixed-latency memory port between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 16-bit pipelined CPU. It sequences each access through a small FSM, holds the address, write data and command stable for the memory's latency, and returns a one-cycle ready pulse with the read data. Requesters stall while req is high and ready is low, and feed that stall into the pipeline's stall logic.

Parameters:
WORD_SIZE, 16, data and address width in bits
MEM_LATENCY, 4, cycles mem_read/mem_write stay asserted per access; legal range 1..15
CNT_WIDTH, 16, width of the per-requester completed-access counters

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_req  input  1  IF fetch request; held until i_ready
i_addr  input  WORD_SIZE  fetch address
i_ready  output  1  one-cycle pulse: fetch done, i_rdata valid
i_rdata  output  WORD_SIZE  fetched instruction; held until next fetch completes
d_req  input  1  MEM access request; held until d_ready
d_we  input  1  1 = store, 0 = load
d_addr  input  WORD_SIZE  data address
d_wdata  input  WORD_SIZE  store data
d_ready  output  1  one-cycle pulse: data access done
d_rdata  output  WORD_SIZE  load data; held until next load completes; stores leave it unchanged
mem_read  output  1  memory read command
mem_write  output  1  memory write command
mem_addr  output  WORD_SIZE  latched address
mem_wdata  output  WORD_SIZE  latched store data
mem_rdata  input  WORD_SIZE  memory read data, valid in last command cycle
busy  output  1  high in BUSY_I, BUSY_D and DONE
i_count  output  CNT_WIDTH  completed fetches, wraps
d_count  output  CNT_WIDTH  completed data accesses, wraps

Behaviour:
- Reset (async, reset_n=0): state IDLE, last_grant=I, all outputs 0, including rdata registers and counters. Reset mid-transaction aborts it; no ready pulse is produced.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, arbitration is evaluated in the cycle; the grant is registered at the clock edge:
  - only d_req -> BUSY_D
  - only i_req -> BUSY_I
  - both -> grant the requester not equal to last_grant (D wins the first conflict after reset)
  - none -> stay IDLE
- Grant edge actions: latch addr, wdata and we; set last_grant; load the latency counter with MEM_LATENCY.
- BUSY_x:
  - mem_read = !we_latched (always 1 for I); mem_write = we_latched.
  - mem_addr and mem_wdata come from the latch; they are stable for exactly MEM_LATENCY cycles.
  - The counter decrements each cycle. When it reaches 1, that cycle's mem_rdata is captured into i_rdata or d_rdata (loads and fetches only), and the FSM moves to DONE.
- DONE: pulse the granted ready for exactly one cycle and increment its counter; mem_read and mem_write are 0; no arbitration in this cycle, so the requester can drop req; next state IDLE.
- Latency: req seen in IDLE at cycle T -> command asserted in T+1..T+MEM_LATENCY -> ready at T+MEM_LATENCY+1. Earliest next grant is evaluated at T+MEM_LATENCY+2.
- No preemption: a req arriving or dropping mid-transaction does not affect the current one. Dropping req before ready is a protocol violation, and the transaction still completes.
- In IDLE and DONE: mem_read = mem_write = 0, and mem_addr and mem_wdata hold their last values.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- MEM_LATENCY=1: a single command cycle, then DONE.

Decomposition:
- Shared constants package: WORD_SIZE, the arbiter state encodings (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DONE=2'd3), and the grant IDs GRANT_I=1'b0 and GRANT_D=1'b1.
- One natural sub-module: mem_latency_counter. It loads MEM_LATENCY on load, decrements on en, outputs last when count==1, and resets asynchronously on reset_n.

Test Plan:
- Single fetch, MEM_LATENCY=4: i_req=1, i_addr=16'h0010 at cycle 0, mem_rdata=16'hA5A5 in cycle 4 -> mem_read high in cycles 1-4, mem_addr=16'h0010; i_ready pulses in cycle 5; i_rdata=16'hA5A5; i_count=1.
- Store: d_req=1, d_we=1, d_addr=16'h0020, d_wdata=16'h1234 -> mem_write high 4 cycles with mem_wdata=16'h1234; mem_read=0; d_ready pulses once; d_rdata unchanged; d_count=1.
- Simultaneous, held requests from reset -> grant order D, I, D, I; each transaction takes 6 cycles, with the next command starting 2 cycles after the prior command ends.
- Load during fetch: d_req rises at cycle 2 of an I transaction -> the I transaction completes unchanged; D is granted in the IDLE cycle after DONE; d_rdata captures the value of its own last command cycle.
- Reset at the 3rd BUSY_D cycle -> all outputs 0 immediately, no d_ready; after release, a held d_req is re-granted from IDLE.
- MEM_LATENCY=1 build: a fetch gives a 1 command cycle and ready at T+2. Preload i_count=16'hFFFF through a forced sequence, then complete one fetch -> i_count=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory port arbiter: data width, FSM state encodings, grant IDs.
package mem_port_arbiter_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times one fixed-latency memory command; last_c flags the final command cycle.
module mem_latency_counter #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic last_c
);

    localparam int unsigned LAT_W = 4;

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= LAT_W'(MEM_LATENCY);
        end else if (en && (count != '0)) begin
            count <= count - LAT_W'(1);
        end
    end

    assign last_c = (count == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access,
// alternating grants on conflict and returning a one-cycle ready pulse per access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ready,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] i_count,
    output logic [CNT_WIDTH-1:0] d_count
);

    arb_state_e state, state_nxt;
    logic       last_grant, grant_nxt;
    logic       we_q, we_nxt;
    logic       lat_load, lat_last;

    mem_latency_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_lat (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (lat_load),
        .en     ((state == BUSY_I) || (state == BUSY_D)),
        .last_c (lat_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
        end
    end

    // Arbitration only in IDLE; on conflict the requester not served last wins.
    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        we_nxt    = we_q;
        lat_load  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = d_req ? GRANT_D : GRANT_I;
                    end
                    state_nxt = (grant_nxt == GRANT_D) ? BUSY_D : BUSY_I;
                    we_nxt    = (grant_nxt == GRANT_D) && d_we;
                    lat_load  = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (lat_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered port outputs, computed from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q      <= 1'b0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            i_count   <= '0;
            d_count   <= '0;
        end else begin
            we_q      <= we_nxt;
            i_ready   <= (state_nxt == DONE) && (grant_nxt == GRANT_I);
            d_ready   <= (state_nxt == DONE) && (grant_nxt == GRANT_D);
            mem_read  <= (state_nxt == BUSY_I) || ((state_nxt == BUSY_D) && !we_nxt);
            mem_write <= (state_nxt == BUSY_D) && we_nxt;
            busy      <= (state_nxt != IDLE);
            if (lat_load) begin
                mem_addr <= (grant_nxt == GRANT_D) ? d_addr : i_addr;
                if (grant_nxt == GRANT_D) begin
                    mem_wdata <= d_wdata;
                end
            end
            if (lat_last && (state == BUSY_I)) begin
                i_rdata <= mem_rdata;
            end
            if (lat_last && (state == BUSY_D) && !we_q) begin
                d_rdata <= mem_rdata;
            end
            if ((state_nxt == DONE) && (state != DONE)) begin
                if (grant_nxt == GRANT_D) begin
                    d_count <= d_count + CNT_WIDTH'(1);
                end else begin
                    i_count <= i_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct packed {
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] mem_rdata;
    } stim_t;

    typedef struct packed {
        logic        i_ready;
        logic        d_ready;
        logic [15:0] i_rdata;
        logic [15:0] d_rdata;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        busy;
        logic [15:0] i_count;
        logic [15:0] d_count;
    } obs_t;

    logic  clk = 1'b0;
    logic  reset_n;
    stim_t s0, s1;
    obs_t  o0, o1;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    chk_en = 1'b0;

    logic        w0_i_ready, w0_d_ready, w0_mem_read, w0_mem_write, w0_busy;
    logic [15:0] w0_i_rdata, w0_d_rdata, w0_mem_addr, w0_mem_wdata, w0_i_count, w0_d_count;
    logic        w1_i_ready, w1_d_ready, w1_mem_read, w1_mem_write, w1_busy;
    logic [15:0] w1_i_rdata, w1_d_rdata, w1_mem_addr, w1_mem_wdata;
    logic [3:0]  w1_i_count, w1_d_count;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.MEM_LATENCY(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(s0.i_req), .i_addr(s0.i_addr), .i_ready(w0_i_ready), .i_rdata(w0_i_rdata),
        .d_req(s0.d_req), .d_we(s0.d_we), .d_addr(s0.d_addr), .d_wdata(s0.d_wdata),
        .d_ready(w0_d_ready), .d_rdata(w0_d_rdata),
        .mem_read(w0_mem_read), .mem_write(w0_mem_write), .mem_addr(w0_mem_addr),
        .mem_wdata(w0_mem_wdata), .mem_rdata(s0.mem_rdata), .busy(w0_busy),
        .i_count(w0_i_count), .d_count(w0_d_count)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .CNT_WIDTH(4)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n),
        .i_req(s1.i_req), .i_addr(s1.i_addr), .i_ready(w1_i_ready), .i_rdata(w1_i_rdata),
        .d_req(s1.d_req), .d_we(s1.d_we), .d_addr(s1.d_addr), .d_wdata(s1.d_wdata),
        .d_ready(w1_d_ready), .d_rdata(w1_d_rdata),
        .mem_read(w1_mem_read), .mem_write(w1_mem_write), .mem_addr(w1_mem_addr),
        .mem_wdata(w1_mem_wdata), .mem_rdata(s1.mem_rdata), .busy(w1_busy),
        .i_count(w1_i_count), .d_count(w1_d_count)
    );

    assign o0 = {w0_i_ready, w0_d_ready, w0_i_rdata, w0_d_rdata, w0_mem_read, w0_mem_write,
                 w0_mem_addr, w0_mem_wdata, w0_busy, w0_i_count, w0_d_count};
    assign o1 = {w1_i_ready, w1_d_ready, w1_i_rdata, w1_d_rdata, w1_mem_read, w1_mem_write,
                 w1_mem_addr, w1_mem_wdata, w1_busy, 12'h000, w1_i_count, 12'h000, w1_d_count};

    // Transaction-level model: m_p counts cycles since the grant edge (1..lat = command, lat+1 = ready).
    int   lat  [2] = '{4, 1};
    int   cmax [2] = '{32'h0000_FFFF, 32'h0000_000F};
    bit   m_act [2];
    bit   m_gnt [2];
    bit   m_we  [2];
    bit   m_last[2];
    int   m_p   [2];
    obs_t e     [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k]  = 1'b0;
            m_gnt[k]  = GRANT_I;
            m_we[k]   = 1'b0;
            m_last[k] = GRANT_I;
            m_p[k]    = 0;
            e[k]      = '0;
        end
    endtask

    task automatic model_step(input int k, input stim_t st);
        if (m_act[k]) begin
            if (m_p[k] == lat[k] && !m_we[k]) begin
                if (m_gnt[k]) e[k].d_rdata = st.mem_rdata;
                else          e[k].i_rdata = st.mem_rdata;
            end
            if (m_p[k] == lat[k] + 1) m_act[k] = 1'b0;
            else                      m_p[k]   = m_p[k] + 1;
        end else if (st.i_req || st.d_req) begin
            m_gnt[k]  = (st.i_req && st.d_req) ? !m_last[k] : st.d_req;
            m_last[k] = m_gnt[k];
            m_act[k]  = 1'b1;
            m_p[k]    = 1;
            m_we[k]   = m_gnt[k] && st.d_we;
            e[k].mem_addr = m_gnt[k] ? st.d_addr : st.i_addr;
            if (m_gnt[k]) e[k].mem_wdata = st.d_wdata;
        end
        e[k].busy      = m_act[k];
        e[k].mem_read  = m_act[k] && (m_p[k] <= lat[k]) && !m_we[k];
        e[k].mem_write = m_act[k] && (m_p[k] <= lat[k]) && m_we[k];
        e[k].i_ready   = m_act[k] && (m_p[k] == lat[k] + 1) && !m_gnt[k];
        e[k].d_ready   = m_act[k] && (m_p[k] == lat[k] + 1) && m_gnt[k];
        if (e[k].i_ready) e[k].i_count = 16'((32'(e[k].i_count) + 1) & cmax[k]);
        if (e[k].d_ready) e[k].d_count = 16'((32'(e[k].d_count) + 1) & cmax[k]);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step(0, s0);
            model_step(1, s1);
        end
    end

    task automatic cmp_obs(input int k, input obs_t a, input obs_t x);
        obs_t aa;
        obs_t xx;
        aa = a;
        xx = x;
        if (!x.mem_write) begin
            aa.mem_wdata = '0;
            xx.mem_wdata = '0;
        end
        n_cmp++;
        if (aa !== xx) begin
            n_bad++;
            $display("FAIL model_u%0d t=%0t got=%h want=%h", k, $time, aa, xx);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_obs(0, o0, e[0]);
            cmp_obs(1, o1, e[1]);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input int k, input int budget, output bit got_d, output int at);
        bit   seen;
        obs_t o;
        seen  = 1'b0;
        got_d = 1'b0;
        at    = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            o = (k == 0) ? o0 : o1;
            if (o.i_ready || o.d_ready) begin
                seen  = 1'b1;
                got_d = o.d_ready;
                at    = cyc;
            end
        end
        check("ready_timeout", seen, 1);
    endtask

    task automatic rand_drive(input stim_t si, input obs_t o, output stim_t so);
        so = si;
        so.mem_rdata = 16'($urandom);
        if (!si.i_req || o.i_ready) begin
            so.i_req  = ($urandom_range(0, 2) != 0);
            so.i_addr = 16'($urandom);
        end
        if (!si.d_req || o.d_ready) begin
            so.d_req   = ($urandom_range(0, 2) != 0);
            so.d_we    = 1'($urandom_range(0, 1));
            so.d_addr  = 16'($urandom);
            so.d_wdata = 16'($urandom);
        end
    endtask

    initial begin
        bit    got_d;
        int    at;
        int    prev;
        stim_t nx;

        s0 = '0;
        s1 = '0;
        reset_n = 1'b0;
        repeat (3) tick();
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        tick();
        check("reset_state", |o0, 0);

        // Single fetch with A5A5 on the last command cycle.
        s0.i_req = 1'b1; s0.i_addr = 16'h0010; s0.mem_rdata = 16'h1111;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("fetch_mem_read", o0.mem_read, 1);
            check("fetch_mem_addr", o0.mem_addr, 16'h0010);
            s0.mem_rdata = (c == 4) ? 16'hA5A5 : 16'h1111;
        end
        tick();
        check("fetch_i_ready", o0.i_ready, 1);
        check("fetch_i_rdata", o0.i_rdata, 16'hA5A5);
        check("fetch_i_count", o0.i_count, 1);
        check("fetch_done_cmd", o0.mem_read, 0);
        s0.i_req = 1'b0;
        tick();
        check("fetch_ready_pulse", o0.i_ready, 0);
        check("fetch_idle_busy", o0.busy, 0);

        // Store.
        s0.d_req = 1'b1; s0.d_we = 1'b1; s0.d_addr = 16'h0020; s0.d_wdata = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("store_mem_write", o0.mem_write, 1);
            check("store_mem_read", o0.mem_read, 0);
            check("store_mem_wdata", o0.mem_wdata, 16'h1234);
        end
        tick();
        check("store_d_ready", o0.d_ready, 1);
        check("store_d_rdata", o0.d_rdata, 0);
        check("store_d_count", o0.d_count, 1);
        s0.d_req = 1'b0; s0.d_we = 1'b0;
        tick();

        // Simultaneous held requests from reset: D, I, D, I, six cycles apart.
        #1 reset_n = 1'b0;
        tick();
        #1 reset_n = 1'b1;
        s0.i_req = 1'b1; s0.i_addr = 16'h0100;
        s0.d_req = 1'b1; s0.d_we = 1'b0; s0.d_addr = 16'h0200;
        prev = 0;
        for (int t = 0; t < 4; t++) begin
            wait_ready(0, 20, got_d, at);
            check("conflict_order", got_d, (t % 2 == 0));
            if (t > 0) check("conflict_spacing", 32'(at - prev), 6);
            prev = at;
        end
        s0.i_req = 1'b0; s0.d_req = 1'b0;
        repeat (2) tick();

        // Load arrives during a fetch; served in the IDLE cycle after DONE.
        s0.i_req = 1'b1; s0.i_addr = 16'h0040;
        for (int c = 0; c <= 10; c++) begin
            s0.mem_rdata = 16'hC000 + 16'(c);
            if (c == 2) begin
                s0.d_req = 1'b1; s0.d_we = 1'b0; s0.d_addr = 16'h0300;
            end
            tick();
            if (c + 1 == 5) begin
                check("lfd_i_ready", o0.i_ready, 1);
                check("lfd_i_rdata", o0.i_rdata, 16'hC004);
                s0.i_req = 1'b0;
            end
            if (c + 1 == 6) check("lfd_idle_cmd", o0.mem_read, 0);
            if (c + 1 == 7) begin
                check("lfd_d_cmd", o0.mem_read, 1);
                check("lfd_d_addr", o0.mem_addr, 16'h0300);
            end
            if (c + 1 == 11) begin
                check("lfd_d_ready", o0.d_ready, 1);
                check("lfd_d_rdata", o0.d_rdata, 16'hC00A);
            end
        end
        s0.d_req = 1'b0;
        tick();

        // Reset in the third BUSY_D cycle, then re-grant of the held request.
        s0.d_req = 1'b1; s0.d_we = 1'b0; s0.d_addr = 16'h0400;
        repeat (3) tick();
        check("rst_pre_busy", o0.busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_all_zero", |o0, 0);
        repeat (2) begin
            tick();
            check("rst_no_ready", o0.d_ready, 0);
        end
        #1 reset_n = 1'b1;
        tick();
        check("rst_regrant_cmd", o0.mem_read, 1);
        check("rst_regrant_addr", o0.mem_addr, 16'h0400);
        repeat (4) tick();
        check("rst_regrant_ready", o0.d_ready, 1);
        check("rst_regrant_count", o0.d_count, 1);
        s0.d_req = 1'b0;
        tick();

        // MEM_LATENCY=1 instance: one command cycle, ready at T+2, 4-bit counter wraps.
        s1.i_req = 1'b1; s1.i_addr = 16'h0050; s1.mem_rdata = 16'h5A5A;
        tick();
        check("l1_cmd", o1.mem_read, 1);
        check("l1_addr", o1.mem_addr, 16'h0050);
        tick();
        check("l1_ready", o1.i_ready, 1);
        check("l1_rdata", o1.i_rdata, 16'h5A5A);
        check("l1_count", o1.i_count, 1);
        for (int n = 2; n <= 16; n++) begin
            wait_ready(1, 10, got_d, at);
            if (n == 15) check("l1_count_max", o1.i_count, 16'h000F);
            if (n == 16) check("l1_count_wrap", o1.i_count, 0);
        end
        s1.i_req = 1'b0;
        repeat (2) tick();

        // Randomized traffic on both instances, with one reset in the middle.
        for (int n = 0; n < 4000; n++) begin
            tick();
            rand_drive(s0, o0, nx); s0 = nx;
            rand_drive(s1, o1, nx); s1 = nx;
            if (n == 2000) begin
                #1 reset_n = 1'b0;
                tick();
                #1 reset_n = 1'b1;
            end
        end
        s0.i_req = 1'b0; s0.d_req = 1'b0;
        s1.i_req = 1'b0; s1.d_req = 1'b0;
        repeat (20) tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
